multicycle_data_path: RTL and testbench
=======================================

Name: multicycle_data_path

Overview:
Parametrised multicycle successor to the single-cycle ARM-subset datapath. Integrates register file, immediate extend, ALU with NZCV flags, and an internal control FSM. Uses one unified instruction/data memory port with a req/ready handshake, so wait-state memories are supported. Top-level CPU core; the memory sits outside this block.

Parameters:
ADDR_W, 32, width of the PC and mem_addr; PC arithmetic wraps mod 2^ADDR_W; legal range 8..32.
RESET_PC, 0, PC value loaded on reset; must be word aligned.
RF_RESET_CLEAR, 1, 1: r0..r14 cleared on reset; 0: register contents undefined after reset.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
mem_req  out  1  memory transaction request.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  ADDR_W  byte address; bits [1:0] always 0.
mem_wdata  out  32  store data.
mem_rdata  in  32  read data; sampled on the edge where mem_req and mem_ready are both high.
mem_ready  in  1  transfer completes on any edge where mem_req and mem_ready are both high.
pc  out  ADDR_W  address of the current or next instruction fetch.
retire  out  1  one-cycle pulse when an instruction completes.
flags  out  4  NZCV.

Behaviour:
- Reset (sync): state = FETCH, pc = RESET_PC, flags = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, retire = 0, instruction register = 0.
- A reset that arrives mid-transaction abandons it: mem_req is low in the cycle after the reset edge, and the pending mem_ready is ignored.
- Handshake: while mem_req is high, mem_addr, mem_we and mem_wdata are held stable until the completing edge. mem_ready may be high in the first request cycle. mem_ready is ignored when mem_req is low.
- FSM states: FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH.
- FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On completion, IR <= mem_rdata, pc <= pc + 4, go to DECODE.
- DECODE:
  - Latch A = R[Rn] and B = R[Rm] (STR: B = R[Rd]). A read of r15 returns pc + 4, i.e. fetch address + 8.
  - Evaluate cond against flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 = false.
  - Cond false, op = 11, or unsupported cmd: retire = 1, go to FETCH (NOP).
- Data processing (op 00):
  - funct[5] = I: 1 uses zero-extended imm8, 0 uses Rm unshifted (instr[11:4] ignored).
  - cmd = funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
  - S = funct[0]. EXEC_R/EXEC_I latch ALUOut and update flags if S = 1 or cmd = CMP.
  - Flag rules: N = bit31, Z = (result == 0). C = carry-out for ADD, NOT borrow for SUB/CMP. V = signed overflow for ADD/SUB/CMP. AND/ORR leave C and V unchanged.
  - ALUWB: Rd <= ALUOut, except CMP, which does not write back. retire = 1.
- Memory (op 01), imm12 offset only, funct[0] = L, funct[3] = U:
  - MEMADR: address = Rn + imm12 if U = 1, else Rn − imm12.
  - LDR: MEMRD (req) -> MEMWB: Rd <= data, retire.
  - STR: MEMWR (req, we = 1, wdata = R[Rd]), retire on completion.
- Branch (op 10), state BRANCH: pc <= (fetch address + 8) + (sext(imm24) << 2), truncated to ADDR_W. retire = 1.
- Any writeback to r15 (ALUWB or MEMWB) loads pc instead of the register file, with result[1:0] forced to 0.
- Minimum latency with zero wait states:
  - cond-fail/NOP: 2 cycles.
  - B: 3 cycles.
  - data processing: 4 cycles.
  - STR: 4 cycles.
  - LDR: 5 cycles.
  - Each wait cycle adds 1.
- retire is high exactly in the final cycle of each instruction and never two cycles in a row.

Optional Feature:
MC_DATA_PATH_BL_EN defined: op 10 with funct[4] = 1 is BL. In the BRANCH state, r14 <= fetch address + 4 on the same edge as the pc update. Undefined: funct[4] is ignored, BL behaves as B, and r14 is untouched.

Test Plan:
- RESET_PC = 0x100, reset held 2 cycles then released -> mem_req = 1 with mem_addr = 0x100 on the first cycle after release; pc = 0x100.
- ADD r1,r0,#5 (E2801005); SUBS r2,r1,#7 (E2512007); STR r2,[r0] (E5802000) with r0 = 0 -> write of 0xFFFFFFFE to address 0, flags N=1 Z=0 C=0 V=0, retire on 3 instructions.
- CMP r0,r0 then BNE +8 (1A000000) -> Z = 1, BNE retires in DECODE 2 cycles after its fetch starts, next fetch = branch address + 4. Then BEQ (0A000000) at 0x20 -> next fetch 0x28.
- LDR r3,[r0,#4] with mem_ready low for 3 cycles in MEMRD -> mem_addr = 4 and mem_we = 0 stable throughout, r3 = mem_rdata, retire 3 cycles later than the zero-wait case.
- Reset asserted during a MEMWR wait -> mem_req low next cycle, pc = RESET_PC, no write completes, flags = 0.
- With MC_DATA_PATH_BL_EN, BL (EB000001) at 0x10 -> r14 = 0x14, next fetch 0x1C. Without the macro -> next fetch 0x1C, r14 unchanged.

Source files
------------

// File: rtl/multicycle_data_path.sv
// Multicycle ARM-subset CPU core: register file, ALU with NZCV, control FSM, single req/ready memory port.
// Optional MC_DATA_PATH_BL_EN: op 10 with funct[4] = 1 also writes the return address to r14.
module multicycle_data_path #(
    parameter int unsigned ADDR_W         = 32,
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter bit          RF_RESET_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic [3:0]        flags
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, mem_addr_q;
    logic [31:0]       ir_q, a_q, b_q, alu_q, data_q, mem_wdata_q;
    logic [3:0]        flags_q;
    logic              mem_req_q, mem_we_q;
    logic [31:0]       rf_q [0:15];

    logic [1:0]        op;
    logic [3:0]        cond, cmd, rn, rd, rm;
    logic              cond_ok, nop_d, wb_pc_d;
    logic [ADDR_W-1:0] pc_plus4_d, br_target_d, next_pc_d;
    logic [31:0]       rn_val_d, rd_val_d, rm_val_d, srcb_d, alu_res_d, addr_calc_d, wb_val_d;
    logic [32:0]       sum_add_d, sum_sub_d;
    logic [3:0]        alu_flags_d;
    logic              c_d, v_d;

    assign cond = ir_q[31:28];
    assign op   = ir_q[27:26];
    assign cmd  = ir_q[24:21];
    assign rn   = ir_q[19:16];
    assign rd   = ir_q[15:12];
    assign rm   = ir_q[3:0];

    // After FETCH pc already holds fetch+4, so r15 reads and branch base are pc+4 (fetch+8).
    assign pc_plus4_d  = pc_q + ADDR_W'(4);
    assign rn_val_d    = (rn == 4'd15) ? 32'(pc_plus4_d) : rf_q[rn];
    assign rd_val_d    = (rd == 4'd15) ? 32'(pc_plus4_d) : rf_q[rd];
    assign rm_val_d    = (rm == 4'd15) ? 32'(pc_plus4_d) : rf_q[rm];
    assign br_target_d = pc_plus4_d + ADDR_W'({{6{ir_q[23]}}, ir_q[23:0], 2'b00});
    assign addr_calc_d = ir_q[23] ? a_q + {20'b0, ir_q[11:0]} : a_q - {20'b0, ir_q[11:0]};

    always_comb begin
        unique case (cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = !flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = !flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = !flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = !flags_q[0];
            4'b1000: cond_ok = flags_q[1] && !flags_q[2];
            4'b1001: cond_ok = !flags_q[1] || flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
        nop_d = !cond_ok || (op == 2'b11) ||
                ((op == 2'b00) && !(cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP}));
    end

    always_comb begin
        srcb_d    = (state_q == EXEC_I) ? {24'b0, ir_q[7:0]} : b_q;
        sum_add_d = {1'b0, a_q} + {1'b0, srcb_d};
        sum_sub_d = {1'b0, a_q} + {1'b0, ~srcb_d} + 33'd1;
        alu_res_d = a_q & srcb_d;
        c_d       = flags_q[1];
        v_d       = flags_q[0];
        case (cmd)
            CMD_ADD: begin
                alu_res_d = sum_add_d[31:0];
                c_d       = sum_add_d[32];
                v_d       = (a_q[31] == srcb_d[31]) && (alu_res_d[31] != a_q[31]);
            end
            CMD_SUB, CMD_CMP: begin
                alu_res_d = sum_sub_d[31:0];
                c_d       = sum_sub_d[32];
                v_d       = (a_q[31] != srcb_d[31]) && (alu_res_d[31] != a_q[31]);
            end
            CMD_ORR: alu_res_d = a_q | srcb_d;
            default: alu_res_d = a_q & srcb_d;
        endcase
        alu_flags_d = {alu_res_d[31], (alu_res_d == 32'h0), c_d, v_d};
    end

    always_comb begin
        wb_val_d  = (state_q == MEMWB) ? data_q : alu_q;
        wb_pc_d   = (rd == 4'd15) && !((state_q == ALUWB) && (cmd == CMD_CMP));
        next_pc_d = wb_pc_d ? ADDR_W'(wb_val_d & ~32'h3) : pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= ADDR_W'(RESET_PC);
            flags_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ir_q        <= '0;
            if (RF_RESET_CLEAR) begin
                for (int unsigned i = 0; i < 15; i++) rf_q[4'(i)] <= '0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    // Request is raised on entry to FETCH; only the first cycle after reset arrives idle.
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        ir_q      <= mem_rdata;
                        pc_q      <= pc_plus4_d;
                        mem_req_q <= 1'b0;
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    a_q <= rn_val_d;
                    b_q <= ((op == 2'b01) && !ir_q[20]) ? rd_val_d : rm_val_d;
                    if (nop_d) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                        state_q    <= FETCH;
                    end else if (op == 2'b00) begin
                        state_q <= ir_q[25] ? EXEC_I : EXEC_R;
                    end else if (op == 2'b01) begin
                        state_q <= MEMADR;
                    end else begin
                        state_q <= BRANCH;
                    end
                end
                EXEC_R, EXEC_I: begin
                    alu_q <= alu_res_d;
                    if (ir_q[20] || (cmd == CMD_CMP)) flags_q <= alu_flags_d;
                    state_q <= ALUWB;
                end
                ALUWB, MEMWB: begin
                    if (!wb_pc_d && !((state_q == ALUWB) && (cmd == CMD_CMP))) rf_q[rd] <= wb_val_d;
                    pc_q       <= next_pc_d;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= next_pc_d;
                    state_q    <= FETCH;
                end
                MEMADR: begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= !ir_q[20];
                    mem_addr_q  <= ADDR_W'(addr_calc_d & ~32'h3);
                    mem_wdata_q <= b_q;
                    state_q     <= ir_q[20] ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    if (mem_ready) begin
                        data_q    <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= MEMWB;
                    end
                end
                MEMWR: begin
                    if (mem_ready) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                        state_q    <= FETCH;
                    end
                end
                BRANCH: begin
`ifdef MC_DATA_PATH_BL_EN
                    if (ir_q[24]) rf_q[14] <= 32'(pc_q);
`endif
                    pc_q       <= br_target_d;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= br_target_d;
                    state_q    <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign retire    = !reset && (((state_q == DECODE) && nop_d) ||
                                  (state_q inside {ALUWB, MEMWB, BRANCH}) ||
                                  ((state_q == MEMWR) && mem_ready));
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_multicycle_data_path.sv
// Scoreboard bench for multicycle_data_path: expected bus transfers are queued per scenario
// and compared against the transfers the DUT completes on the memory port.
module tb_multicycle_data_path;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

`ifdef MC_DATA_PATH_BL_EN
    localparam logic [31:0] R14_EXP = 32'h128;
`else
    localparam logic [31:0] R14_EXP = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  flags;

    logic [31:0] mem [0:255];
    xfer_t       exp_q[$], obs_q[$];
    int          ret_q[$];
    int          n_vec = 0, n_err = 0, cycle = 0, retire_cnt = 0, stall_left = 0;
    logic        s_req, s_we, s_ready, s_ret;
    logic [31:0] s_addr, s_wdata;

    multicycle_data_path #(.ADDR_W(32), .RESET_PC(32'h100), .RF_RESET_CLEAR(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .flags(flags)
    );

    always #5 clk = ~clk;

    function automatic xfer_t xf(input logic we, input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.we = we; x.addr = a; x.data = d;
        return x;
    endfunction

    // One clock cycle: answer the memory port, sample outputs, log completed transfers/retires.
    task automatic step();
        xfer_t x;
        if (mem_req && mem_addr < 32'h100 && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        mem_rdata = mem[mem_addr[9:2]];
        #1;
        s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
        s_ready = mem_ready; s_ret = retire;
        @(posedge clk);
        cycle++;
        if (!reset) begin
            if (s_ret) begin
                retire_cnt++;
                ret_q.push_back(cycle);
            end
            if (s_req && s_ready) begin
                x = xf(s_we, s_addr, s_we ? s_wdata : 32'h0);
                obs_q.push_back(x);
                if (s_we) mem[s_addr[9:2]] = s_wdata;
            end
        end
        #1;
    endtask

    task automatic run_retires(input int n, input int budget);
        for (int i = 0; i < budget && retire_cnt < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0b want 0", mem_we); end
        n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL rst_pc: got %h want 100", pc); end
        n_vec++; if (flags !== 4'h0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", flags); end
        n_vec++; if (retire !== 1'b0) begin n_err++; $display("FAIL rst_retire: got %0b want 0", retire); end
        reset = 1'b0;
        step();
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rel_req: got %0b want 1", mem_req); end
        n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL rel_addr: got %h want 100", mem_addr); end
        n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL rel_pc: got %h want 100", pc); end
        retire_cnt = 0; obs_q.delete(); ret_q.delete();
    endtask

    task automatic test_alu_store();
        xfer_t e, o;
        int base = cycle;
        int want[3] = '{4, 8, 12};
        retire_cnt = 0; ret_q.delete();
        exp_q.push_back(xf(1'b0, 32'h100, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h104, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h108, 32'h0));
        exp_q.push_back(xf(1'b1, 32'h0, 32'hFFFF_FFFE));
        run_retires(3, 40);
        n_vec++; if (ret_q.size() !== 3) begin n_err++; $display("FAIL alu_retires: got %0d want 3", ret_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (ret_q[i] - base !== want[i]) begin n_err++; $display("FAIL alu_latency%0d: got %0d want %0d", i, ret_q[i] - base, want[i]); end
        end
        n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL alu_flags: got %b want 1000", flags); end
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL alu_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL alu_xfer: got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_cond_branch();
        xfer_t e, o;
        int base = cycle;
        int want[3] = '{4, 6, 9};
        retire_cnt = 0; ret_q.delete();
        exp_q.push_back(xf(1'b0, 32'h10C, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h110, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h114, 32'h0));
        run_retires(3, 40);
        n_vec++; if (ret_q.size() !== 3) begin n_err++; $display("FAIL br_retires: got %0d want 3", ret_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (ret_q[i] - base !== want[i]) begin n_err++; $display("FAIL br_latency%0d: got %0d want %0d", i, ret_q[i] - base, want[i]); end
        end
        n_vec++; if (flags !== 4'b0110) begin n_err++; $display("FAIL br_flags: got %b want 0110", flags); end
        n_vec++; if (pc !== 32'h11C) begin n_err++; $display("FAIL br_pc: got %h want 11c", pc); end
        n_vec++; if (mem_addr !== 32'h11C || mem_req !== 1'b1) begin n_err++; $display("FAIL br_next_fetch: got req=%0b addr=%h want req=1 addr=11c", mem_req, mem_addr); end
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL br_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL br_xfer: got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wait_states();
        xfer_t e, o;
        int base = cycle;
        int want[2] = '{8, 12};
        logic pw = 1'b0, pwe = 1'b0;
        logic [31:0] pa = 32'h0;
        retire_cnt = 0; ret_q.delete();
        stall_left = 3;
        exp_q.push_back(xf(1'b0, 32'h11C, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h4, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h120, 32'h0));
        exp_q.push_back(xf(1'b1, 32'hC, 32'hCAFE_F00D));
        for (int i = 0; i < 40 && retire_cnt < 2; i++) begin
            step();
            if (pw) begin
                n_vec++;
                if (s_req !== 1'b1 || s_addr !== pa || s_we !== pwe) begin
                    n_err++;
                    $display("FAIL wait_hold: got req=%0b addr=%h we=%0b want req=1 addr=%h we=%0b", s_req, s_addr, s_we, pa, pwe);
                end
            end
            pw = s_req && !s_ready; pa = s_addr; pwe = s_we;
        end
        n_vec++; if (ret_q.size() !== 2) begin n_err++; $display("FAIL wait_retires: got %0d want 2", ret_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (ret_q[i] - base !== want[i]) begin n_err++; $display("FAIL wait_latency%0d: got %0d want %0d", i, ret_q[i] - base, want[i]); end
        end
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL wait_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL wait_xfer: got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bl();
        xfer_t e, o;
        int base = cycle;
        int want[2] = '{3, 7};
        retire_cnt = 0; ret_q.delete();
        exp_q.push_back(xf(1'b0, 32'h124, 32'h0));
        exp_q.push_back(xf(1'b0, 32'h130, 32'h0));
        exp_q.push_back(xf(1'b1, 32'h10, R14_EXP));
        run_retires(2, 40);
        n_vec++; if (ret_q.size() !== 2) begin n_err++; $display("FAIL bl_retires: got %0d want 2", ret_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (ret_q[i] - base !== want[i]) begin n_err++; $display("FAIL bl_latency%0d: got %0d want %0d", i, ret_q[i] - base, want[i]); end
        end
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bl_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL bl_xfer: got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midwrite();
        int nwr = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        retire_cnt = 0; obs_q.delete(); ret_q.delete();
        stall_left = 1000;
        for (int i = 0; i < 40 && !(s_req && s_we); i++) step();
        step();
        step();
        n_vec++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0) begin
            n_err++; $display("FAIL mid_pending: got req=%0b we=%0b addr=%h want req=1 we=1 addr=0", mem_req, mem_we, mem_addr);
        end
        n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL mid_flags_pre: got %b want 1000", flags); end
        stall_left = 0;
        reset = 1'b1;
        step();
        n_vec++; if (s_ret !== 1'b0) begin n_err++; $display("FAIL mid_retire: got %0b want 0", s_ret); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_req: got %0b want 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_we: got %0b want 0", mem_we); end
        n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL mid_pc: got %h want 100", pc); end
        n_vec++; if (flags !== 4'h0) begin n_err++; $display("FAIL mid_flags: got %b want 0000", flags); end
        reset = 1'b0;
        step();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL mid_refetch: got req=%0b we=%0b addr=%h want req=1 we=0 addr=100", mem_req, mem_we, mem_addr);
        end
        foreach (obs_q[i]) if (obs_q[i].we) nwr++;
        n_vec++; if (nwr !== 0) begin n_err++; $display("FAIL mid_no_write: got %0d writes want 0", nwr); end
        obs_q.delete(); ret_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1]  = 32'hCAFE_F00D;
        mem[64] = 32'hE280_1005;  // 0x100 ADD  r1,r0,#5
        mem[65] = 32'hE251_2007;  // 0x104 SUBS r2,r1,#7
        mem[66] = 32'hE580_2000;  // 0x108 STR  r2,[r0]
        mem[67] = 32'hE150_0000;  // 0x10C CMP  r0,r0
        mem[68] = 32'h1A00_0000;  // 0x110 BNE  0x118
        mem[69] = 32'h0A00_0000;  // 0x114 BEQ  0x11C
        mem[70] = 32'hE580_1008;  // 0x118 skipped
        mem[71] = 32'hE590_3004;  // 0x11C LDR  r3,[r0,#4]
        mem[72] = 32'hE580_300C;  // 0x120 STR  r3,[r0,#12]
        mem[73] = 32'hEB00_0001;  // 0x124 BL   0x130
        mem[74] = 32'hE580_1008;  // 0x128 skipped
        mem[75] = 32'hE580_1008;  // 0x12C skipped
        mem[76] = 32'hE580_E010;  // 0x130 STR  r14,[r0,#16]
        mem[77] = 32'hEAFF_FFFE;  // 0x134 B    .
        @(posedge clk);
        #1;
        test_reset();
        test_alu_store();
        test_cond_branch();
        test_wait_states();
        test_bl();
        test_reset_midwrite();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
